// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Packs MIPS instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses, one word per accepted transfer.
// A host sequencer drives the field bundles through a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse: (re)start a load at address 0
//   in_valid/in_ready   field bundle handshake (in_ready is combinational)
//   in_last             bundle is the final instruction of the program
//   op, rs, rt, rd,
//   shamt, func, imm,
//   target              instruction fields; format chosen by op
//   imem_we/addr/wdata  registered instruction-memory write port
//   count               words written since the last start
//   busy                high while in LOAD
//   done                one-cycle pulse aligned with the final write
//   overflow            sticky: memory filled before in_last was seen
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic                wptr_full;
  logic [31:0]         packed_word;

  // A start pulse in LOAD takes priority over any offered bundle.
  assign in_ready  = (state_q == LOAD) && !start;
  assign accept    = in_valid && in_ready;
  assign wptr_full = (wptr_q == ADDR_W'(DEPTH - 1));

  // Instruction format selection by opcode.
  always_comb begin
    packed_word = {op, rs, rt, imm};
    if (op == 6'h00) begin
      packed_word = {op, rs, rt, rd, shamt, func};
    end else if ((op == 6'h02) || (op == 6'h03)) begin
      packed_word = {op, target};
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          wptr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (start) begin
          wptr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = wptr_q;
          wdata_d = packed_word;
          count_d = count_q + (ADDR_W+1)'(1);
          if (in_last || wptr_full) begin
            // Final write: either the program ended or the memory is full.
            // Overflow only when the memory ran out before in_last.
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = !in_last;
          end
          // The pointer saturates at the top address instead of wrapping.
          if (!wptr_full) begin
            wptr_d = wptr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign busy       = (state_q == LOAD);
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        op;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        func;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              overflow;

  int nvec = 0;
  int nerr = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .func       (func),
    .imm        (imm),
    .target     (target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: inputs change on the falling edge only.
  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                            input logic [15:0] im, input logic [25:0] tg, input logic last);
    op = o; rs = s; rt = t; rd = d; shamt = sh; func = f; imm = im; target = tg;
    in_last = last;
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    nvec++; if (imem_we !== 1'b0) begin nerr++; $display("FAIL rst_we got %b want 0", imem_we); end
    nvec++; if (imem_addr !== 6'd0) begin nerr++; $display("FAIL rst_addr got %0d want 0", imem_addr); end
    nvec++; if (imem_wdata !== 32'h0) begin nerr++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    nvec++; if (count !== 7'd0) begin nerr++; $display("FAIL rst_count got %0d want 0", count); end
    nvec++; if ({busy, done, overflow} !== 3'b000) begin nerr++; $display("FAIL rst_flags got %b want 000", {busy, done, overflow}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_rtype;
    do_start;
    #1;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL r_busy got %b want 1", busy); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL r_ready got %b want 1", in_ready); end
    set_fields(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 26'h3FFFFFF, 1'b1);
    @(posedge clk); #1;
    $display("rtype write addr=%0d data=%h", imem_addr, imem_wdata);
    nvec++; if (imem_we !== 1'b1) begin nerr++; $display("FAIL r_we got %b want 1", imem_we); end
    nvec++; if (imem_addr !== 6'd0) begin nerr++; $display("FAIL r_addr got %0d want 0", imem_addr); end
    nvec++; if (imem_wdata !== 32'h00221820) begin nerr++; $display("FAIL r_wdata got %h want 00221820", imem_wdata); end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL r_done got %b want 1", done); end
    nvec++; if (count !== 7'd1) begin nerr++; $display("FAIL r_count got %0d want 1", count); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL r_busy_end got %b want 0", busy); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL r_ready_idle got %b want 0", in_ready); end
  endtask

  task automatic test_i_j;
    do_start;
    set_fields(6'h08, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h1234567, 1'b0);
    @(posedge clk); #1;
    $display("itype write addr=%0d data=%h", imem_addr, imem_wdata);
    nvec++; if (imem_addr !== 6'd0) begin nerr++; $display("FAIL i_addr got %0d want 0", imem_addr); end
    nvec++; if (imem_wdata !== 32'h2022FFFF) begin nerr++; $display("FAIL i_wdata got %h want 2022FFFF", imem_wdata); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL i_done got %b want 0", done); end
    @(negedge clk);
    set_fields(6'h02, 5'd7, 5'd7, 5'd7, 5'd7, 6'h07, 16'h7777, 26'h0000010, 1'b1);
    @(posedge clk); #1;
    $display("jtype write addr=%0d data=%h", imem_addr, imem_wdata);
    nvec++; if (imem_we !== 1'b1) begin nerr++; $display("FAIL j_we got %b want 1", imem_we); end
    nvec++; if (imem_addr !== 6'd1) begin nerr++; $display("FAIL j_addr got %0d want 1", imem_addr); end
    nvec++; if (imem_wdata !== 32'h08000010) begin nerr++; $display("FAIL j_wdata got %h want 08000010", imem_wdata); end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL j_done got %b want 1", done); end
    nvec++; if (count !== 7'd2) begin nerr++; $display("FAIL j_count got %0d want 2", count); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    nvec++; if ({imem_we, done} !== 2'b00) begin nerr++; $display("FAIL j_after got %b want 00", {imem_we, done}); end
    nvec++; if (imem_addr !== 6'd1) begin nerr++; $display("FAIL j_hold_addr got %0d want 1", imem_addr); end
  endtask

  // Fill the whole memory; last_at_end marks the 64th bundle as in_last.
  task automatic test_fill(input logic last_at_end);
    logic [31:0] exp_w;
    logic        fin;
    do_start;
    for (int i = 0; i < DEPTH; i++) begin
      fin = (i == DEPTH - 1);
      set_fields(6'h0D, 5'(i), 5'd0, 5'd9, 5'd9, 6'h09, 16'(i * 3), 26'h0, last_at_end & fin);
      exp_w = {6'h0D, 5'(i), 5'd0, 16'(i * 3)};
      @(posedge clk); #1;
      nvec++; if (imem_we !== 1'b1 || imem_addr !== 6'(i)) begin nerr++; $display("FAIL fill_addr i=%0d got we=%b addr=%0d want we=1 addr=%0d", i, imem_we, imem_addr, i); end
      nvec++; if (imem_wdata !== exp_w) begin nerr++; $display("FAIL fill_wdata i=%0d got %h want %h", i, imem_wdata, exp_w); end
      nvec++; if (count !== 7'(i + 1)) begin nerr++; $display("FAIL fill_count i=%0d got %0d want %0d", i, count, i + 1); end
      nvec++; if (done !== fin) begin nerr++; $display("FAIL fill_done i=%0d got %b want %b", i, done, fin); end
      nvec++; if (overflow !== (fin & ~last_at_end)) begin nerr++; $display("FAIL fill_ovf i=%0d got %b want %b", i, overflow, fin & ~last_at_end); end
      @(negedge clk);
    end
    $display("fill done last_at_end=%b count=%0d overflow=%b", last_at_end, count, overflow);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL fill_ready_after got %b want 0", in_ready); end
    @(posedge clk); #1;
    nvec++; if (imem_we !== 1'b0) begin nerr++; $display("FAIL fill_no_write got %b want 0", imem_we); end
    nvec++; if (count !== 7'd64) begin nerr++; $display("FAIL fill_count_hold got %0d want 64", count); end
    nvec++; if (overflow !== ~last_at_end) begin nerr++; $display("FAIL fill_ovf_hold got %b want %b", overflow, ~last_at_end); end
    @(negedge clk);
    in_valid = 1'b0;
    do_start;
    #1;
    nvec++; if (overflow !== 1'b0 || count !== 7'd0) begin nerr++; $display("FAIL fill_restart got ovf=%b count=%0d want ovf=0 count=0", overflow, count); end
  endtask

  task automatic test_restart;
    do_start;
    for (int i = 0; i < 2; i++) begin
      set_fields(6'h08, 5'(i), 5'd1, 5'd0, 5'd0, 6'h0, 16'h1000, 26'h0, 1'b0);
      @(posedge clk); #1;
      nvec++; if (imem_addr !== 6'(i)) begin nerr++; $display("FAIL rs_pre_addr got %0d want %0d", imem_addr, i); end
      @(negedge clk);
    end
    start = 1'b1;
    set_fields(6'h08, 5'd3, 5'd3, 5'd0, 5'd0, 6'h0, 16'h2222, 26'h0, 1'b0);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rs_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    nvec++; if (imem_we !== 1'b0) begin nerr++; $display("FAIL rs_we got %b want 0", imem_we); end
    nvec++; if (count !== 7'd0 || busy !== 1'b1) begin nerr++; $display("FAIL rs_state got count=%0d busy=%b want count=0 busy=1", count, busy); end
    @(negedge clk);
    start = 1'b0;
    set_fields(6'h00, 5'd4, 5'd5, 5'd6, 5'd2, 6'h02, 16'h0, 26'h0, 1'b1);
    @(posedge clk); #1;
    $display("restart write addr=%0d data=%h", imem_addr, imem_wdata);
    nvec++; if (imem_we !== 1'b1 || imem_addr !== 6'd0) begin nerr++; $display("FAIL rs_addr got we=%b addr=%0d want we=1 addr=0", imem_we, imem_addr); end
    nvec++; if (imem_wdata !== 32'h00853082) begin nerr++; $display("FAIL rs_wdata got %h want 00853082", imem_wdata); end
    nvec++; if (count !== 7'd1 || done !== 1'b1) begin nerr++; $display("FAIL rs_count got count=%0d done=%b want 1 1", count, done); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    do_start;
    for (int i = 0; i < 3; i++) begin
      set_fields(6'h08, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'(i), 26'h0, 1'b0);
      @(posedge clk); #1;
      nvec++; if (imem_addr !== 6'(i) || count !== 7'(i + 1)) begin nerr++; $display("FAIL ar_pre i=%0d got addr=%0d count=%0d", i, imem_addr, count); end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if ({in_ready, imem_we, busy, done, overflow} !== 5'b0) begin nerr++; $display("FAIL ar_flags got %b want 00000", {in_ready, imem_we, busy, done, overflow}); end
    nvec++; if (imem_addr !== 6'd0 || imem_wdata !== 32'h0 || count !== 7'd0) begin nerr++; $display("FAIL ar_vals got addr=%0d data=%h count=%0d want 0", imem_addr, imem_wdata, count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL ar_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    nvec++; if (imem_we !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL ar_idle got we=%b busy=%b want 0 0", imem_we, busy); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_random_valid;
    int          n;
    int          cyc;
    logic        v;
    logic [31:0] exp_w;
    n = 0;
    cyc = 0;
    do_start;
    while (n < 10 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      set_fields(6'h23, 5'(n), 5'(n + 1), 5'd0, 5'd0, 6'h0, 16'(n * 16'h111), 26'h0, n == 9);
      in_valid = v;
      exp_w = {6'h23, 5'(n), 5'(n + 1), 16'(n * 16'h111)};
      @(posedge clk); #1;
      nvec++; if (imem_we !== v) begin nerr++; $display("FAIL rv_we cyc=%0d got %b want %b", cyc, imem_we, v); end
      if (v) begin
        $display("random write addr=%0d data=%h", imem_addr, imem_wdata);
        nvec++; if (imem_addr !== 6'(n) || imem_wdata !== exp_w) begin nerr++; $display("FAIL rv_word n=%0d got addr=%0d data=%h want addr=%0d data=%h", n, imem_addr, imem_wdata, n, exp_w); end
        nvec++; if (done !== (n == 9) || count !== 7'(n + 1)) begin nerr++; $display("FAIL rv_count n=%0d got done=%b count=%0d", n, done, count); end
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    nvec++; if (n != 10) begin nerr++; $display("FAIL rv_timeout got %0d writes want 10", n); end
    @(posedge clk); #1;
    nvec++; if (imem_we !== 1'b0 || count !== 7'd10) begin nerr++; $display("FAIL rv_end got we=%b count=%0d want 0 10", imem_we, count); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; func = '0; imm = '0; target = '0;
    test_reset;
    test_rtype;
    test_i_j;
    test_fill(1'b0);
    test_fill(1'b1);
    test_restart;
    test_async_reset;
    test_random_valid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader that assembles MIPS-format instruction fields (op, rs, rt, rd, shamt, func, imm, target) into 32-bit instruction words and writes them sequentially into the instruction memory. It is the encode/write side of the fetch path: it produces, at consecutive addresses, the words the fetch and IF/ID stages later read back and split into fields. It is driven by a test or host sequencer through a valid/ready handshake, one instruction per accepted transfer.

## Interface
- ADDR_W, 6, instruction-memory address width; DEPTH = 2**ADDR_W words.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new load at address 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader accepts the bundle this cycle.
- in_last  in  1  bundle is the final instruction of the program.
- op  in  6  opcode.
- rs, rt, rd  in  5 each  register fields.
- shamt  in  5  shift amount (R-type).
- func  in  6  function code (R-type).
- imm  in  16  immediate (I-type).
- target  in  26  jump target (J-type).
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  packed instruction word.
- count  out  ADDR_W+1  words written since last start.
- busy  out  1  high in LOAD state.
- done  out  1  one-cycle pulse with the final write.
- overflow  out  1  sticky: memory filled before in_last seen.

## Operation
- States: IDLE, LOAD. Reset → IDLE.
- IDLE: in_ready=0. start=1 → LOAD; write pointer wptr←0, count←0, overflow←0.
- LOAD: in_ready = ~start (combinational). Accept = in_valid & in_ready.
- start in LOAD restarts: wptr←0, count←0, overflow←0, stays in LOAD; no bundle accepted that cycle.
- Packing (by op of accepted bundle):
  - op==6'h00 → R: {op, rs, rt, rd, shamt, func}.
  - op==6'h02 or 6'h03 → J: {op, target}.
  - otherwise → I: {op, rs, rt, imm}.
  - Fields unused by the selected format are ignored.
- On accept: imem_wdata←packed word, imem_addr←wptr, imem_we←1 (registered, next cycle); wptr←wptr+1; count←count+1.
- Termination on accept:
  - in_last=1 → IDLE; done pulses with that write.
  - in_last=0 and wptr==DEPTH-1 → IDLE; done pulses; overflow←1 (held until next start or reset).
  - in_last=1 at wptr==DEPTH-1 → IDLE, done, overflow stays 0.
- No accept → imem_we←0; imem_addr/imem_wdata hold last values.
- wptr never wraps; count max DEPTH.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, busy=0, done=0, overflow=0; state IDLE, wptr=0.
- rst_n low mid-load: immediate return to reset values; partially loaded memory contents untouched; no further writes.
- Latency: accept at edge N → imem_we=1, addr/data valid in cycle N+1; count increments at same edge.
- Throughput: one instruction per cycle with in_valid held high.
- busy rises the cycle after start; in_ready may be high that cycle.
- done and imem_we for the final word are asserted in the same cycle; busy is 0 in that cycle.
- in_valid without in_ready: bundle not consumed; the source holds it.

## Test plan
- Reset, start, then R-type op=0 rs=1 rt=2 rd=3 shamt=0 func=0x20 with in_last=1 → one cycle later imem_we=1, addr=0, wdata=0x00221820, done=1, count=1, busy=0.
- I-type op=0x08 rs=1 rt=2 imm=0xFFFF, then J-type op=0x02 target=0x0000010 (in_last) → addr0=0x2022FFFF, addr1=0x08000010, done with second write, count=2.
- Stream DEPTH=64 bundles, in_last never set → writes 0..63, done and overflow=1 with addr 63, in_ready=0 afterwards; next start clears overflow and count.
- start asserted mid-stream with in_valid=1 → in_ready=0 that cycle, no write; next accepted bundle written to addr 0, count=1.
- rst_n pulsed low after 3 writes → all outputs 0 asynchronously, in_ready=0 until next start.
- in_valid toggled randomly over 10 bundles → exactly 10 writes, consecutive addresses 0..9, no duplicates or drops.
